// File: rtl/psum_accumulator.sv
// Per-lane partial-sum accumulator with bit-serial shift-add (mode 0) or plain-add (mode 1) jobs.
// Define PSUM_ACC_SAT_EN to clamp each lane update to the signed ACC_WIDTH range instead of wrapping.
module psum_accumulator #(
  parameter int NUM_LANES  = 12,
  parameter int PSUM_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            mode,
  input  logic                            start,
  input  logic [3:0]                      num_beats,
  input  logic                            in_valid,
  input  logic [NUM_LANES*PSUM_WIDTH-1:0] partial_sums,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*ACC_WIDTH-1:0]  acc_out,
  output logic                            busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [3:0]           nbeats_q, nbeats_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           cnt_inc;
  logic                 negate;
  logic [ACC_WIDTH-1:0] acc_q [NUM_LANES];
  logic [ACC_WIDTH-1:0] acc_d [NUM_LANES];

`ifdef PSUM_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH+1:0] SAT_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH+1:0] SAT_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};
`endif

  function automatic logic [ACC_WIDTH-1:0] lane_next(
    input logic [ACC_WIDTH-1:0] acc,
    input logic [ACC_WIDTH-1:0] ps,
    input logic                 plain,
    input logic                 neg
  );
`ifdef PSUM_ACC_SAT_EN
    logic signed [ACC_WIDTH+1:0] acc_w;
    logic signed [ACC_WIDTH+1:0] ps_w;
    logic signed [ACC_WIDTH+1:0] sum_w;
    acc_w = (ACC_WIDTH+2)'($signed(acc));
    ps_w  = (ACC_WIDTH+2)'($signed(ps));
    if (neg)        sum_w = -ps_w;
    else if (plain) sum_w = acc_w + ps_w;
    else            sum_w = (acc_w <<< 1) + ps_w;
    if (sum_w > SAT_MAX)      return SAT_MAX[ACC_WIDTH-1:0];
    else if (sum_w < SAT_MIN) return SAT_MIN[ACC_WIDTH-1:0];
    else                      return sum_w[ACC_WIDTH-1:0];
`else
    if (neg)        return '0 - ps;
    else if (plain) return acc + ps;
    else            return (acc << 1) + ps;
`endif
  endfunction

  assign cnt_inc   = cnt_q + 4'd1;
  // First beat of a multi-beat shift-add job carries the negative-weight MSB plane.
  assign negate    = !mode_q && (cnt_q == 4'd0) && (nbeats_q != 4'd1);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUTPUT);
  assign busy      = (state_q != IDLE);

  always_comb begin
    logic [ACC_WIDTH-1:0] ps_ext;
    state_d  = state_q;
    mode_d   = mode_q;
    nbeats_d = nbeats_q;
    cnt_d    = cnt_q;
    ps_ext   = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) acc_d[k] = acc_q[k];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          nbeats_d = (num_beats == 4'd0) ? 4'd1 : num_beats;
          cnt_d    = '0;
          for (int unsigned k = 0; k < NUM_LANES; k++) acc_d[k] = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < NUM_LANES; k++) begin
            ps_ext   = ACC_WIDTH'($signed(partial_sums[k*PSUM_WIDTH +: PSUM_WIDTH]));
            acc_d[k] = lane_next(acc_q[k], ps_ext, mode_q, negate);
          end
          cnt_d = cnt_inc;
          if (cnt_inc == nbeats_q) state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      nbeats_q <= 4'd1;
      cnt_q    <= '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) acc_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      nbeats_q <= nbeats_d;
      cnt_q    <= cnt_d;
      for (int unsigned k = 0; k < NUM_LANES; k++) acc_q[k] <= acc_d[k];
    end
  end

  always_comb begin
    acc_out = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) acc_out[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[k];
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: closed-form lane model, randomized jobs, directed corner cases.
module tb_psum_accumulator;

  localparam int NL = 12;
  localparam int PW = 16;
  localparam int AW = 24;
  localparam int LW = NL * AW;

  typedef logic [NL*PW-1:0] beat_t;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic          start;
  logic [3:0]    num_beats;
  logic          in_valid;
  beat_t         partial_sums;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] acc_out;
  logic          busy;

  logic          s_mode, s_start, s_iv, s_ir, s_ov, s_or, s_busy;
  logic [3:0]    s_nb;
  logic [15:0]   s_ps;
  logic [15:0]   s_acc;

  int            checks = 0;
  int            failures = 0;
  logic [LW-1:0] exp_q[$];
  beat_t         beats_q[$];
  logic          held = 1'b0;
  logic [LW-1:0] held_val = '0;
  logic [LW-1:0] last_acc;

  psum_accumulator #(.NUM_LANES(NL), .PSUM_WIDTH(PW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .num_beats(num_beats),
    .in_valid(in_valid), .partial_sums(partial_sums), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .busy(busy)
  );

  psum_accumulator #(.NUM_LANES(1), .PSUM_WIDTH(16), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .mode(s_mode), .start(s_start), .num_beats(s_nb),
    .in_valid(s_iv), .partial_sums(s_ps), .in_ready(s_ir),
    .out_valid(s_ov), .out_ready(s_or), .acc_out(s_acc), .busy(s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic beat_t rand_ps();
    beat_t p;
    for (int k = 0; k < NL; k++) p[k*PW +: PW] = PW'($urandom);
    return p;
  endfunction

  // Mode 0 treats the beats as bit planes of a two's-complement weight, MSB first.
  function automatic logic [LW-1:0] model(input bit m, input beat_t bq[$]);
    logic [LW-1:0] r;
    int            n;
    longint        v;
    longint        s;
    logic [63:0]   vv;
    logic [PW-1:0] raw;
    beat_t         b;
    r = '0;
    n = bq.size();
    for (int k = 0; k < NL; k++) begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        b   = bq[i];
        raw = b[k*PW +: PW];
        s   = longint'($signed(raw));
`ifdef PSUM_ACC_SAT_EN
        if (m)                 v = v + s;
        else if (i == 0 && n > 1) v = -s;
        else                   v = 2 * v + s;
        if (v > (longint'(1) <<< (AW-1)) - 1) v = (longint'(1) <<< (AW-1)) - 1;
        if (v < -(longint'(1) <<< (AW-1)))    v = -(longint'(1) <<< (AW-1));
`else
        if (m) v = v + s;
        else   v = v + ((i == 0 && n > 1) ? -s : s) * (longint'(1) <<< (n-1-i));
`endif
      end
      vv = v;
      r[k*AW +: AW] = vv[AW-1:0];
    end
    return r;
  endfunction

  task automatic run_job(input bit m, input logic [3:0] nb, input int hold);
    int n;
    n = (nb == 4'd0) ? 1 : int'(nb);
    @(negedge clk);
    start = 1'b1; mode = m; num_beats = nb;
    exp_q.push_back(model(m, beats_q));
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom); num_beats = 4'($urandom);
    chk1("busy_accum", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; partial_sums = rand_ps();
        @(negedge clk);
      end
      chk1("in_ready_accum", in_ready, 1'b1);
      chk1("out_valid_early", out_valid, 1'b0);
      in_valid = 1'b1; partial_sums = beats_q[i];
      mode = 1'($urandom); num_beats = 4'($urandom);
      @(negedge clk);
    end
    chk1("out_valid_latency", out_valid, 1'b1);
    chk1("in_ready_output", in_ready, 1'b0);
    last_acc = acc_out;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); partial_sums = rand_ps(); start = 1'($urandom);
      @(negedge clk);
    end
    // start during the handshake cycle must not launch a job
    in_valid = 1'b0; start = 1'($urandom); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    chk1("idle_after_handshake", busy, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_acc_out", acc_out, '0);
        held = 1'b0;
      end else begin
        if (held) begin
          chk1("hold_out_valid", out_valid, 1'b1);
          chkw("hold_acc_out", acc_out, held_val);
        end
        if (out_valid && out_ready) begin
          chk1("handshake_in_ready", in_ready, 1'b0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%h required=none", acc_out);
          end else begin
            chkw("result", acc_out, exp_q.pop_front());
          end
        end
        held     = out_valid && !out_ready;
        held_val = acc_out;
      end
    end
  end

  initial begin
    beat_t b;
    int    nb;
    rst_n = 1'b0; mode = 1'b0; start = 1'b0; num_beats = '0; in_valid = 1'b0;
    partial_sums = '0; out_ready = 1'b0;
    s_mode = 1'b1; s_start = 1'b0; s_nb = '0; s_iv = 1'b0; s_ps = '0; s_or = 1'b0;
    repeat (3) @(negedge clk);
    chkw("reset_acc16", LW'(s_acc), '0);
    rst_n = 1'b1;

    beats_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = rand_ps();
      b[PW-1:0] = (i == 0) ? 16'd5 : (i == 1) ? 16'd3 : 16'd2;
      beats_q.push_back(b);
    end
    run_job(1'b0, 4'd3, 0);
    chkw("msb_first_lane0", LW'(last_acc[AW-1:0]), LW'(24'hFFFFF4));

    beats_q.delete();
    repeat (4) beats_q.push_back({NL{16'h7FFF}});
    run_job(1'b1, 4'd4, 2);
    chkw("plain_add_all_lanes", last_acc, {NL{24'h01FFFC}});

    beats_q.delete();
    repeat (2) beats_q.push_back(rand_ps());
    run_job(1'b0, 4'd2, 5);

    @(negedge clk);
    start = 1'b1; mode = 1'b0; num_beats = 4'd3;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; partial_sums = {NL{16'h0123}};
    @(negedge clk);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_in_ready", in_ready, 1'b0);
    chk1("async_rst_out_valid", out_valid, 1'b0);
    chkw("async_rst_acc_out", acc_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    beats_q.delete();
    beats_q.push_back({NL{16'hFFF9}});
    run_job(1'b1, 4'd1, 0);
    chkw("post_reset_neg7", LW'(last_acc[AW-1:0]), LW'(24'hFFFFF9));

    beats_q.delete();
    beats_q.push_back({NL{16'd9}});
    run_job(1'b0, 4'd0, 1);
    chkw("zero_beats_as_one", LW'(last_acc[AW-1:0]), LW'(24'd9));

    for (int j = 0; j < 25; j++) begin
      nb = $urandom_range(0, 15);
      beats_q.delete();
      repeat ((nb == 0) ? 1 : nb) beats_q.push_back(rand_ps());
      run_job(1'($urandom), 4'(nb), $urandom_range(0, 3));
    end

    @(negedge clk);
    s_start = 1'b1; s_mode = 1'b1; s_nb = 4'd15;
    @(negedge clk);
    s_start = 1'b0; s_mode = 1'b0; s_iv = 1'b1; s_ps = 16'h7FFF;
    repeat (15) @(negedge clk);
    s_iv = 1'b0;
    chk1("acc16_out_valid", s_ov, 1'b1);
`ifdef PSUM_ACC_SAT_EN
    chkw("acc16_limit", LW'(s_acc), LW'(16'h7FFF));
`else
    chkw("acc16_limit", LW'(s_acc), LW'(16'(15 * 32767)));
`endif
    s_or = 1'b1;
    @(negedge clk);
    s_or = 1'b0;
    chk1("acc16_idle", s_busy, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL results_pending actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter NUM_LANES, default 12, number of 16b partial-sum lanes.
REQ-002 SHALL have parameter PSUM_WIDTH, default 16, width of each incoming lane.
REQ-003 SHALL have parameter ACC_WIDTH, default 24, width of each accumulator lane.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mode  input  1  0 = multi-bit bit-serial (shift-add), 1 = 1-bit mode (plain add).
REQ-007 SHALL have port start  input  1  begin a new accumulation job.
REQ-008 SHALL have port num_beats  input  4  number of beats per job; 0 treated as 1.
REQ-009 SHALL have port in_valid  input  1  partial_sums beat valid.
REQ-010 SHALL have port partial_sums  input  NUM_LANES*PSUM_WIDTH  lane k at bits [16k+15:16k], two's complement.
REQ-011 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-012 SHALL have port out_valid  output  1  accumulated result available.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port acc_out  output  NUM_LANES*ACC_WIDTH  lane k at [24k+23:24k].
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ACCUM -> OUTPUT -> IDLE.
REQ-017 In IDLE, start SHALL latch mode and num_beats (0 -> 1), clear all accumulators and beat counter, and enter ACCUM next cycle.
REQ-018 start outside IDLE SHALL be ignored; mode/num_beats changes after latch SHALL have no effect.
REQ-019 in_ready SHALL equal (state == ACCUM); beats while in_ready = 0 SHALL be dropped.
REQ-020 Each lane SHALL sign-extend its PSUM_WIDTH input to ACC_WIDTH before use.
REQ-021 Latched mode 0: per accepted beat acc = (acc << 1) + psum, except on the first beat when num_beats > 1, where acc = 0 - psum (MSB plane of two's-complement weight, MSB first).
REQ-022 Latched mode 1: per accepted beat acc = acc + psum, no shift, no negation.
REQ-023 Beat counter SHALL increment per accepted beat; the beat making count == num_beats SHALL move FSM to OUTPUT on the same edge as the final accumulator update.
REQ-024 In OUTPUT, out_valid SHALL be 1 and acc_out SHALL hold stable until out_ready = 1; on out_valid & out_ready FSM returns to IDLE next cycle.
REQ-025 acc_out SHALL be registered accumulator contents; latency from last accepted beat to out_valid = 1 cycle.
REQ-026 Without saturation, arithmetic SHALL wrap modulo 2^ACC_WIDTH.
REQ-027 start asserted in the same cycle as an out_valid & out_ready handshake SHALL be ignored (FSM not yet IDLE).

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, all accumulators 0, beat counter 0, latched mode 0, latched num_beats 1.
REQ-029 During/after reset in_ready = 0, out_valid = 0, busy = 0, acc_out = 0.
REQ-030 Reset mid-job SHALL discard the job; no partial result is ever presented.

Configuration
REQ-031 Macro PSUM_ACC_SAT_EN defined: each lane update SHALL be computed at ACC_WIDTH+2 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-032 Macro PSUM_ACC_SAT_EN undefined: no clamp logic; wrap per REQ-026.

Verification
REQ-033 Mode 0, num_beats=3, lane 0 psums 5,3,2 -> acc_out lane 0 = ((-5)*2+3)*2+2 = -12 (0xFFFFF4), out_valid 1 cycle after third beat.
REQ-034 Mode 1, num_beats=4, all lanes psum 0x7FFF each beat -> every lane 0x01FFFC; in_ready low in OUTPUT.
REQ-035 out_ready held 0 for 5 cycles in OUTPUT -> acc_out and out_valid stable, extra in_valid beats and start ignored; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low after 1 of 3 beats -> all outputs 0 immediately; new job of num_beats=1, psum -7 (mode 1) -> lane = -7.
REQ-037 num_beats=0, mode 0, psum 9 -> treated as 1 beat, no negation, result 9.
REQ-038 Mode 1, num_beats=15, psum 0x7FFF on all beats, ACC_WIDTH=16: with PSUM_ACC_SAT_EN -> 0x7FFF; without -> wrapped 0x7FF1.
